display_driver: RTL and testbench
=================================

# display_driver

Two-digit seven-segment display driver sitting directly downstream of the frequency counter core. It accepts a binary edge count (0–99) with a load strobe and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It time-multiplexes the two digits onto one shared 7-segment bus plus a digit-select line, matching the counter's `uo_out[6:0]` / `uo_out[7]` pin mapping. Out-of-range counts are shown as "--".

## Interface
- `REFRESH_CYCLES`, default 1200: clock cycles per digit slot; legal range 2..4095.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `count_in` input 7: binary count to display; values 100..127 are out of range.
- `load` input 1: one-cycle strobe; samples `count_in`.
- `busy` output 1: high while a conversion is in progress (CONVERT or UPDATE).
- `segments` output 7: {g,f,e,d,c,b,a}, active-high, registered.
- `digit` output 1: 0 = units digit driven, 1 = tens digit driven; registered.

## Operation
- FSM states: IDLE, CONVERT, UPDATE.
  - IDLE: `load`, or a pending load, latches the value into a 15-bit shift register {tens[3:0], units[3:0], bin[6:0]}; records the range flag (value > 99); sets iteration counter to 0; goes to CONVERT.
  - CONVERT: each cycle adds 3 to any BCD nibble ≥ 5, then shifts left 1. After 7 iterations it goes to UPDATE.
  - UPDATE: writes display registers `tens_q`, `units_q`, then returns to IDLE. If the range flag is set, both registers get code 4'hF (dash).
- Load arriving while `busy`:
  - The value is stored in a one-deep pending register; the latest value wins and earlier pending values are discarded.
  - The pending value is converted on the first IDLE cycle.
  - `load` in the same cycle as UPDATE also becomes pending.
- Decode: 0–9 map to the standard patterns (0 = 7'b0111111, 1 = 7'b0000110, 7 = 7'b0000111, 8 = 7'b1111111). 4'hF maps to dash 7'b1000000. Codes A–E map to blank 7'b0000000.
- Refresh:
  - Counter runs 0..REFRESH_CYCLES-1, then wraps to 0.
  - On the terminal-count cycle, `digit` toggles.
  - The counter runs free, independent of the FSM and of `load`.
- `segments` is registered each cycle as decode(`digit` ? `tens_q` : `units_q`), using the current-cycle `digit` register value. Segments therefore lag a digit toggle by exactly one cycle.

## Timing
- Reset values:
  - FSM IDLE; `busy` 0; pending empty.
  - Refresh counter 0; `digit` 0.
  - `tens_q` and `units_q` 0.
  - `segments` 7'b0000000.
- First edge after reset release: `segments` shows units "0" (7'b0111111).
- Load latency:
  - `load` sampled at edge N.
  - `busy` high from after edge N until after edge N+8.
  - Display registers update at edge N+8.
  - `segments` reflects the new value at edge N+9, for whichever digit is selected.
- Back-to-back loads: throughput is one conversion per 9 cycles. At most one pending value is held.
- Reset asserted mid-conversion: the conversion and pending value are discarded and all state returns to reset values on that edge.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - Defined: when `tens_q` == 0, the tens slot drives 7'b0000000 (blank). A value of 5 shows " 5"; a value of 0 shows " 0". The dash code is not affected.
  - Undefined: the tens slot always shows its digit, so 5 shows "05".
  - Applies only to decode of the tens slot. Timing is identical in both builds.

## Test plan
- Reset, then hold `load`=0 → `digit` toggles every REFRESH_CYCLES cycles; `segments` shows 7'b0111111 in both slots. With `LEADING_ZERO_BLANK_EN`, the tens slot shows 7'b0000000.
- `load` with `count_in`=87 at edge N → `busy` high for 8 cycles; `segments`=7'b1111111 in the tens slot and 7'b0000111 in the units slot from edge N+9.
- `count_in`=100 and `count_in`=127 → both slots show 7'b1000000. Then `count_in`=42 → normal "42".
- Loads of 11, 22, 33 on consecutive cycles while busy → 11 is converted, 33 is converted next, 22 is never displayed. Final display is "33" after 18 cycles.
- `rst_n` low at cycle 4 of a conversion of 56 → all outputs return to reset values. "56" never appears; a subsequent load of 9 converts normally.
- `load` exactly on an UPDATE cycle → the value is pending, conversion starts the next cycle, and `busy` stays high continuously.

Source files
------------

// File: rtl/display_driver_if.sv
// Handshake bundle between the frequency counter core and the display driver.
// The counter side is the master; the display driver is the slave.
interface display_driver_if;
    logic [6:0] count_in;
    logic       load;
    logic       busy;
    logic [6:0] segments;
    logic       digit;

    modport master (
        output count_in,
        output load,
        input  busy,
        input  segments,
        input  digit
    );

    modport slave (
        input  count_in,
        input  load,
        output busy,
        output segments,
        output digit
    );
endinterface

// File: rtl/display_driver.sv
// Two-digit multiplexed 7-segment driver with a sequential double-dabble BCD converter.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module display_driver #(
    parameter int REFRESH_CYCLES = 1200
) (
    input  logic       clk,
    input  logic       rst_n,
    display_driver_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

    localparam logic [11:0] REFRESH_TC = 12'(REFRESH_CYCLES - 1);
    localparam logic [3:0]  DASH = 4'hF;

    state_t      state;
    state_t      state_nx;
    logic [14:0] shreg;
    logic [2:0]  iter;
    logic        over;
    logic        pend_valid;
    logic [6:0]  pend_val;
    logic [3:0]  tens_q;
    logic [3:0]  units_q;
    logic [11:0] refresh_cnt;
    logic        digit_q;
    logic [6:0]  segments_q;

    logic        start;
    logic [6:0]  start_val;
    logic [3:0]  tens_adj;
    logic [3:0]  units_adj;
    logic [3:0]  shown;
    logic [6:0]  seg_nx;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] seg;
        seg = 7'b0000000;
        case (code)
            4'd0: seg = 7'b0111111;
            4'd1: seg = 7'b0000110;
            4'd2: seg = 7'b1011011;
            4'd3: seg = 7'b1001111;
            4'd4: seg = 7'b1100110;
            4'd5: seg = 7'b1101101;
            4'd6: seg = 7'b1111101;
            4'd7: seg = 7'b0000111;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1101111;
            4'hF: seg = 7'b1000000;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    // A fresh load in IDLE is newer than anything pending, so it wins.
    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        start_val = bus.count_in;
        unique case (state)
            IDLE: begin
                if (bus.load) begin
                    start    = 1'b1;
                    state_nx = CONVERT;
                end else if (pend_valid) begin
                    start     = 1'b1;
                    start_val = pend_val;
                    state_nx  = CONVERT;
                end
            end
            CONVERT: begin
                if (iter == 3'd6) begin
                    state_nx = UPDATE;
                end
            end
            UPDATE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        tens_adj  = shreg[14:11];
        units_adj = shreg[10:7];
        if (tens_adj >= 4'd5) begin
            tens_adj = tens_adj + 4'd3;
        end
        if (units_adj >= 4'd5) begin
            units_adj = units_adj + 4'd3;
        end
    end

    always_comb begin
        shown  = digit_q ? tens_q : units_q;
        seg_nx = decode(shown);
`ifdef LEADING_ZERO_BLANK_EN
        if (digit_q && (tens_q == 4'd0)) begin
            seg_nx = 7'b0000000;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg      <= '0;
            iter       <= '0;
            over       <= 1'b0;
            pend_valid <= 1'b0;
            pend_val   <= '0;
            tens_q     <= '0;
            units_q    <= '0;
        end else begin
            if (start) begin
                shreg <= {8'd0, start_val};
                over  <= (start_val > 7'd99);
                iter  <= '0;
            end else if (state == CONVERT) begin
                shreg <= {tens_adj[2:0], units_adj, shreg[6:0], 1'b0};
                iter  <= iter + 3'd1;
            end
            if (state == UPDATE) begin
                tens_q  <= over ? DASH : shreg[14:11];
                units_q <= over ? DASH : shreg[10:7];
            end
            if (bus.load && (state != IDLE)) begin
                pend_valid <= 1'b1;
                pend_val   <= bus.count_in;
            end else if (start) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_q     <= 1'b0;
            segments_q  <= '0;
        end else begin
            if (refresh_cnt == REFRESH_TC) begin
                refresh_cnt <= '0;
                digit_q     <= ~digit_q;
            end else begin
                refresh_cnt <= refresh_cnt + 12'd1;
            end
            segments_q <= seg_nx;
        end
    end

    // A pending value keeps busy asserted across the IDLE hand-off cycle.
    assign bus.busy     = (state != IDLE) || pend_valid;
    assign bus.segments = segments_q;
    assign bus.digit    = digit_q;

endmodule

// File: tb/tb_display_driver.sv
// Randomized and directed bench for display_driver against a transaction-level model.
// Model tracks conversion countdowns and decimal arithmetic, not RTL state.
module tb_display_driver;

    localparam int R = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    display_driver_if bus ();

    display_driver #(
        .REFRESH_CYCLES(R)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int         m_k;
    int         m_tens;
    int         m_units;
    int         m_left;
    int         m_cur;
    bit         m_pend_v;
    int         m_pend;
    logic [6:0] m_seg;
    logic       m_dig;
    logic       m_busy;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] pattern(input int code);
        logic [6:0] lut [10];
        lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (code >= 0 && code <= 9) return lut[code];
        if (code == 15) return 7'h40;
        return 7'h00;
    endfunction

    task automatic model_edge(input bit r, input bit ld, input int val);
        bit start;
        int sv;
        if (!r) begin
            m_k = 0;
            m_tens = 0;
            m_units = 0;
            m_left = 0;
            m_cur = 0;
            m_pend_v = 0;
            m_pend = 0;
            m_seg = 7'h00;
            m_dig = 1'b0;
        end else begin
            m_seg = pattern(m_dig ? m_tens : m_units);
`ifdef LEADING_ZERO_BLANK_EN
            if (m_dig && m_tens == 0) m_seg = 7'h00;
`endif
            start = 0;
            sv = 0;
            if (m_left == 0) begin
                if (ld) begin
                    start = 1;
                    sv = val;
                    m_pend_v = 0;
                end else if (m_pend_v) begin
                    start = 1;
                    sv = m_pend;
                    m_pend_v = 0;
                end
            end else if (ld) begin
                m_pend_v = 1;
                m_pend = val;
            end
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_cur > 99) begin
                        m_tens = 15;
                        m_units = 15;
                    end else begin
                        m_tens = m_cur / 10;
                        m_units = m_cur % 10;
                    end
                end
            end
            if (start) begin
                m_left = 8;
                m_cur = sv;
            end
            m_k++;
            m_dig = logic'((m_k / R) % 2);
        end
        m_busy = (m_left > 0) || m_pend_v;
    endtask

    task automatic step(input bit r, input bit ld, input int val);
        rst_n = r;
        bus.load = ld;
        bus.count_in = 7'(val);
        @(posedge clk);
        model_edge(r, ld, val);
        #1;
        check("segments", 32'(bus.segments), 32'(m_seg));
        check("digit", 32'(bus.digit), 32'(m_dig));
        check("busy", 32'(bus.busy), 32'(m_busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0);
    endtask

    task automatic load(input int v);
        step(1, 1, v);
    endtask

    initial begin
        bus.load = 1'b0;
        bus.count_in = '0;
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        idle(2 * R + 3);

        load(87);
        idle(2 * R + 10);

        load(100);
        idle(2 * R + 10);
        load(127);
        idle(2 * R + 10);
        load(42);
        idle(2 * R + 10);

        load(11);
        load(22);
        load(33);
        idle(2 * R + 20);

        load(56);
        idle(3);
        step(0, 0, 0);
        idle(2 * R + 4);
        load(9);
        idle(2 * R + 10);

        load(40);
        idle(7);
        load(63);
        idle(2 * R + 12);

        load(5);
        idle(2 * R + 10);
        load(0);
        idle(2 * R + 10);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(0, 0, 0);
            end else if ($urandom_range(0, 3) == 0) begin
                step(1, 1, int'($urandom_range(0, 127)));
            end else begin
                step(1, 0, 0);
            end
        end
        idle(2 * R + 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
